// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encoding and
// program-counter constants used by the sequencer and the external PC register.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        DELIVER
    } fetch_state_t;

    localparam logic [31:0] RESET_PC = 32'hFFFFFFFC;
    localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the external PC register through pcNext,
// issues memory requests, delivers fetched words and handles redirects.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] pc,
    output logic [N-1:0] pcNext,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [N-1:0] imem_rdata,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_target,
    output logic         instr_valid,
    output logic [N-1:0] instr,
    output logic [N-1:0] instr_pc,
    output logic         misalign_err,
    output logic [31:0]  instr_count
);

    fetch_state_t state;
    logic         pend_valid;
    logic [N-1:0] pend_target;
    logic [N-1:0] count_unused_guard;
    logic [31:0]  count;
    logic [N-1:0] redir_tgt;
    logic [N-1:0] pc_step;

    assign count_unused_guard = '0;

    always_comb begin
        redir_tgt    = {redirect_target[N-1:2], 2'b00};
        pc_step      = pc + N'(PC_STEP);
        imem_req     = (state == REQ);
        imem_addr    = pc;
        instr_valid  = (state == DELIVER) && !redirect_valid;
        misalign_err = redirect_valid && (state != BOOT) && (redirect_target[1:0] != 2'b00);
        instr_count  = count;
        pcNext       = pc;
        if (!reset) begin
            unique case (state)
                BOOT: pcNext = pc_step;
                REQ: begin
                    // A redirect in the ack cycle supersedes any older pending one
                    if (imem_ack && redirect_valid)
                        pcNext = redir_tgt;
                    else if (imem_ack && pend_valid)
                        pcNext = pend_target;
                end
                DELIVER: begin
                    if (redirect_valid)
                        pcNext = redir_tgt;
                    else if (!stall)
                        pcNext = pc_step;
                end
                default: pcNext = pc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            count       <= '0;
        end else begin
            unique case (state)
                BOOT: state <= REQ;
                REQ: begin
                    if (imem_ack) begin
                        if (redirect_valid || pend_valid) begin
                            pend_valid <= 1'b0;
                            state      <= REQ;
                        end else begin
                            instr    <= imem_rdata;
                            instr_pc <= pc;
                            state    <= DELIVER;
                        end
                    end else if (redirect_valid) begin
                        pend_valid  <= 1'b1;
                        pend_target <= redir_tgt;
                    end
                end
                DELIVER: begin
                    if (redirect_valid) begin
                        state <= REQ;
                    end else if (!stall) begin
                        count <= count + 32'd1;
                        state <= REQ;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule
